xmul_serial_radix: RTL
======================

Name: xmul_serial_radix

Overview:
- Parametrised successor to the team's serial shift-add multiplier.
- Processes RADIX_W multiplier bits per cycle, giving a selectable area/latency trade-off.
- Supports signed (two's complement) and unsigned operands, chosen per operation.
- Keeps the start/done level handshake used by the existing serial arithmetic blocks, and adds a busy flag and asynchronous reset.

Parameters:
- DATA_W, 32: operand width; product is 2*DATA_W.
- RADIX_W, 1: multiplier bits consumed per iteration. Legal values are 1, 2, 4 or 8, and must divide DATA_W; elaboration fails otherwise.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level request; sampled only in IDLE.
- op_signed  input  1  1 = operands are two's complement, 0 = unsigned; latched with operands.
- op_a  input  DATA_W  multiplicand; latched when start is accepted.
- op_b  input  DATA_W  multiplier; latched when start is accepted.
- done  output  1  product valid; held in DONE.
- busy  output  1  high in RUN and SIGN states.
- product  output  2*DATA_W  result register; holds last result until the next accept or reset.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE; done=0, busy=0, product=0; internal counters and registers cleared.
  - Reset asserted mid-operation aborts the operation immediately; no done pulse follows.
- N = DATA_W/RADIX_W iterations.
- IDLE:
  - On a posedge with start=1 (the accept edge, edge 0):
    - latch op_a, op_b, op_signed;
    - compute magnitudes |a|, |b| when op_signed=1 (raw values when op_signed=0);
    - record neg = op_signed & (a_msb ^ b_msb);
    - clear accumulator; iteration counter=0; go to RUN.
  - Magnitude of the most negative value (2^(DATA_W-1)) is represented unsigned in DATA_W bits; no overflow.
- RUN, edges 1..N:
  - Each edge adds |a| * (low RADIX_W bits of remaining multiplier) to the upper accumulator half (DATA_W+RADIX_W bit adder).
  - Then shifts the accumulator/multiplier pair right by RADIX_W; counter increments.
  - At edge N go to SIGN.
- SIGN, edge N+1:
  - product <= neg ? -(acc) : acc, in 2*DATA_W two's complement.
  - done <= 1, busy <= 0; go to DONE.
- DONE:
  - done stays 1 and product stays stable while start=1.
  - First posedge with start=0 returns to IDLE and clears done; product is retained.
- Latency: done rises N+1 cycles after the accept edge.
  - DATA_W=32, RADIX_W=1: 33 cycles.
  - DATA_W=32, RADIX_W=4: 9 cycles.
- Operand and mode changes after the accept edge are ignored.
- start is ignored in RUN and SIGN.
- If start falls during RUN, the operation completes, done is high for exactly one cycle, then the block returns to IDLE.
- start held high continuously never re-triggers; a new operation requires a pass through IDLE with start sampled high.
- busy and done are never high together.
- product is not updated except at the SIGN edge and at reset.

Test Plan:
1. Signed, DATA_W=32, RADIX_W=1, op_a=-10, op_b=-10 -> done exactly 33 cycles after accept; product=64'd100. Repeat with op_a=3, op_b=-1 -> 64'hFFFFFFFF_FFFFFFFD.
2. Unsigned, op_a=3, op_b=32'hFFFFFFFF -> product=64'h00000002_FFFFFFFD. Same operands with op_signed=1 -> 64'hFFFFFFFF_FFFFFFFD.
3. Corner values, unsigned 32'hFFFFFFFF * 32'hFFFFFFFF -> 64'hFFFFFFFE_00000001. Signed 32'h80000000 * 32'h80000000 -> 64'h40000000_00000000. Zero operands (0*1, 1*0) -> 0.
4. RADIX_W=4 and RADIX_W=8 rebuilds, randomised signed and unsigned operands vs. reference model -> exact match; done at 9 and 5 cycles respectively.
5. Handshake:
   - start held high through DONE for 10 cycles -> done stays 1, no re-accept;
   - start dropped in mid-RUN -> single-cycle done, then IDLE;
   - operands changed in RUN -> result uses latched values.
6. Assert rst at iteration 10 of RUN -> done, busy and product are 0 immediately. After release, start with 7*6 -> 42 with full latency.

Source files
------------

// File: rtl/xmul_serial_radix.sv
// Serial shift-add multiplier consuming RADIX_W multiplier bits per cycle.
// Signed operands are handled as magnitudes, and the product is negated in a final SIGN cycle.
module xmul_serial_radix #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RADIX_W = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                op_signed,
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    output logic                done,
    output logic                busy,
    output logic [2*DATA_W-1:0] product
);
    localparam int unsigned N     = DATA_W / RADIX_W;
    localparam int unsigned SUM_W = DATA_W + RADIX_W;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (!(RADIX_W == 1 || RADIX_W == 2 || RADIX_W == 4 || RADIX_W == 8) ||
        (DATA_W % RADIX_W) != 0) begin : g_param_check
        $error("xmul_serial_radix: RADIX_W must be 1, 2, 4 or 8 and divide DATA_W");
    end

    typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_mag;
    logic [2*DATA_W-1:0] acc;
    logic [CNT_W-1:0]    cnt;
    logic                neg;

    logic [DATA_W-1:0]   a_abs;
    logic [DATA_W-1:0]   b_abs;
    logic [SUM_W-1:0]    partial;
    logic [SUM_W-1:0]    step_sum;
    logic [DATA_W-1:0]   lo_next;

    // acc holds {partial sum, remaining multiplier}; each step adds into the
    // upper half and shifts the whole pair right by RADIX_W.
    always_comb begin
        a_abs    = (op_signed && op_a[DATA_W-1]) ? -op_a : op_a;
        b_abs    = (op_signed && op_b[DATA_W-1]) ? -op_b : op_b;
        partial  = SUM_W'(a_mag) * SUM_W'(acc[RADIX_W-1:0]);
        step_sum = SUM_W'(acc[2*DATA_W-1:DATA_W]) + partial;
        lo_next  = (acc[DATA_W-1:0] >> RADIX_W) |
                   (DATA_W'(step_sum[RADIX_W-1:0]) << (DATA_W - RADIX_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            busy    <= 1'b0;
            product <= '0;
            a_mag   <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_mag <= a_abs;
                        acc   <= {{DATA_W{1'b0}}, b_abs};
                        cnt   <= '0;
                        neg   <= op_signed & (op_a[DATA_W-1] ^ op_b[DATA_W-1]);
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc <= {step_sum[SUM_W-1:RADIX_W], lo_next};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(N - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    product <= neg ? -acc : acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= DONE;
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
